// File: rtl/digit_serial_pkg.sv
// Shared definitions for the digit-serial deserializer: default digit
// geometry, derived word width, output FSM state type and a counter-width
// helper.
package digit_serial_pkg;

   localparam int DW_DEF   = 4;
   localparam int NDIG_DEF = 3;
   localparam int WW_DEF   = DW_DEF * NDIG_DEF;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // Bits needed to count digit slots 0..n-1; never less than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/digit_collector.sv
// Digit collector: tracks the digit slot counter and the partial word.
// Digits arrive least-significant first; gaps (in_valid=0) freeze the
// counter and the partial slots. On the last digit it raises done and
// presents the assembled word (last digit taken straight from s) plus the
// carry that accompanied that last digit.
module digit_collector
   import digit_serial_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NDIG = NDIG_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DW-1:0]      s,
   input  logic               c,
   output logic               done,
   output logic [DW*NDIG-1:0] asm_word,
   output logic               asm_carry
);

   localparam int CW = cnt_width(NDIG);

   logic [CW-1:0] dcnt_reg;
   logic [CW-1:0] dcnt_next;
   logic          last_digit;

   // Only the first NDIG-1 digits need storage; the final one is used live.
   logic [DW-1:0] slot_reg [NDIG-1];

   assign last_digit = (dcnt_reg == CW'(NDIG - 1));
   assign done       = in_valid & last_digit;
   assign asm_carry  = c;

   // Next slot index: advance on valid digits, wrap after the last slot.
   always_comb begin
      dcnt_next = dcnt_reg;
      if (in_valid) begin
         dcnt_next = last_digit ? '0 : dcnt_reg + CW'(1);
      end
   end

   // Slot counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dcnt_reg <= '0;
      end else begin
         dcnt_reg <= dcnt_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NDIG - 1; gi++) begin : g_slot
         // Capture s into this slot when it is the current digit position.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               slot_reg[gi] <= '0;
            end else if (in_valid && (dcnt_reg == CW'(gi))) begin
               slot_reg[gi] <= s;
            end
         end
         assign asm_word[gi*DW +: DW] = slot_reg[gi];
      end
   endgenerate

   assign asm_word[(NDIG-1)*DW +: DW] = s;

endmodule

// File: rtl/digit_serial_deser.sv
// Digit-serial deserializer top: collects NDIG digits of DW bits into a
// word and hands it out through a valid/ready output register. A word that
// completes while the previous one is still unaccepted is dropped and the
// sticky ovf flag is raised.
// Optional feature macro DIGIT_DESER_SAT_EN: when defined, a word that
// completes with cout=1 is delivered as all ones.
module digit_serial_deser
   import digit_serial_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NDIG = NDIG_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [DW-1:0]      s,
   input  logic               c,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DW*NDIG-1:0] word,
   output logic               cout,
   output logic               ovf
);

   localparam int WW = DW * NDIG;

   logic          done;
   logic [WW-1:0] asm_word;
   logic          asm_carry;
   logic [WW-1:0] load_word;

   state_t        state_reg;
   state_t        state_next;
   logic [WW-1:0] word_reg;
   logic          cout_reg;
   logic          ovf_reg;
   logic          ovf_next;
   logic          load;

   digit_collector #(
      .DW   (DW),
      .NDIG (NDIG)
   ) u_collector (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .s         (s),
      .c         (c),
      .done      (done),
      .asm_word  (asm_word),
      .asm_carry (asm_carry)
   );

`ifdef DIGIT_DESER_SAT_EN
   assign load_word = asm_carry ? {WW{1'b1}} : asm_word;
`else
   assign load_word = asm_word;
`endif

   // Output FSM: decide next state, whether to load a new word, and overflow.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      ovf_next   = ovf_reg;
      case (state_reg)
         EMPTY: begin
            if (done) begin
               state_next = FULL;
               load       = 1'b1;
            end
         end
         FULL: begin
            if (done) begin
               if (out_ready) begin
                  load = 1'b1;
               end else begin
                  ovf_next = 1'b1;
               end
            end else if (out_ready) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // State, output word and sticky overflow registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= EMPTY;
         word_reg  <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         ovf_reg   <= ovf_next;
         if (load) begin
            word_reg <= load_word;
            cout_reg <= asm_carry;
         end
      end
   end

   assign out_valid = (state_reg == FULL);
   assign word      = word_reg;
   assign cout      = cout_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_digit_serial_deser.sv
// Directed testbench for digit_serial_deser (DW=4, NDIG=3).
module tb_digit_serial_deser;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [3:0]  s;
   logic        c;
   logic        out_ready;
   logic        out_valid;
   logic [11:0] word;
   logic        cout;
   logic        ovf;

   int n_checks = 0;
   int n_pass   = 0;

   digit_serial_deser #(
      .DW   (4),
      .NDIG (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .s         (s),
      .c         (c),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .word      (word),
      .cout      (cout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_digit(input logic [3:0] d, input logic cc);
      in_valid = 1'b1;
      s        = d;
      c        = cc;
      step();
      in_valid = 1'b0;
      c        = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; s = '0; c = 1'b0; out_ready = 1'b0;
      step(); step();
      n_checks++;
      if ({out_valid, word, cout, ovf} !== 15'd0)
         $display("FAIL reset_outputs: got v=%b w=%h c=%b o=%b want all 0", out_valid, word, cout, ovf);
      else n_pass++;
      rst_n = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0)
         $display("FAIL reset_idle_valid: got %b want 0", out_valid);
      else n_pass++;
      $display("txn reset: v=%b w=%h", out_valid, word);
   endtask

   task automatic test_basic();
      logic [11:0] exp_w;
`ifdef DIGIT_DESER_SAT_EN
      exp_w = 12'hFFF;
`else
      exp_w = 12'h9CB;
`endif
      out_ready = 1'b1;
      send_digit(4'hB, 1'b0);
      send_digit(4'hC, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0)
         $display("FAIL basic_early_valid: got %b want 0", out_valid);
      else n_pass++;
      send_digit(4'h9, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || word !== exp_w || cout !== 1'b1)
         $display("FAIL basic_word: got v=%b w=%h c=%b want v=1 w=%h c=1", out_valid, word, cout, exp_w);
      else n_pass++;
      $display("txn basic: w=%h cout=%b", word, cout);
      step();
      n_checks++;
      if (out_valid !== 1'b0)
         $display("FAIL basic_drain: got %b want 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_gap();
      out_ready = 1'b1;
      send_digit(4'h1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0)
            $display("FAIL gap_idle_valid: got %b want 0", out_valid);
         else n_pass++;
      end
      send_digit(4'h2, 1'b1);
      n_checks++;
      if (out_valid !== 1'b0)
         $display("FAIL gap_early_valid: got %b want 0", out_valid);
      else n_pass++;
      send_digit(4'h3, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || word !== 12'h321 || cout !== 1'b0)
         $display("FAIL gap_word: got v=%b w=%h c=%b want v=1 w=321 c=0", out_valid, word, cout);
      else n_pass++;
      $display("txn gap: w=%h cout=%b", word, cout);
      step();
   endtask

   task automatic test_back_to_back();
      logic [11:0] words [5];
      logic [11:0] w;
      words = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF};
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         w = words[k];
         for (int d = 0; d < 3; d++) begin
            in_valid = 1'b1;
            s        = w[d*4 +: 4];
            c        = (d != 2);
            step();
            n_checks++;
            if (d == 2) begin
               if (out_valid !== 1'b1 || word !== w || cout !== 1'b0)
                  $display("FAIL b2b_word%0d: got v=%b w=%h c=%b want v=1 w=%h c=0", k, out_valid, word, cout, w);
               else n_pass++;
               $display("txn b2b %0d: w=%h", k, word);
            end else begin
               if (out_valid !== 1'b0)
                  $display("FAIL b2b_valid%0d_%0d: got %b want 0", k, d, out_valid);
               else n_pass++;
            end
         end
      end
      in_valid = 1'b0;
      c = 1'b0;
      step();
      n_checks++;
      if (ovf !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL b2b_end: got ovf=%b v=%b want ovf=0 v=0", ovf, out_valid);
      else n_pass++;
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int d = 0; d < 3; d++) send_digit(4'h1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || word !== 12'h111 || ovf !== 1'b0)
         $display("FAIL ovf_first: got v=%b w=%h o=%b want v=1 w=111 o=0", out_valid, word, ovf);
      else n_pass++;
      send_digit(4'h2, 1'b0);
      send_digit(4'h2, 1'b0);
      n_checks++;
      if (word !== 12'h111 || out_valid !== 1'b1)
         $display("FAIL ovf_hold: got v=%b w=%h want v=1 w=111", out_valid, word);
      else n_pass++;
      send_digit(4'h2, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || word !== 12'h111 || cout !== 1'b0 || ovf !== 1'b1)
         $display("FAIL ovf_drop: got v=%b w=%h c=%b o=%b want v=1 w=111 c=0 o=1", out_valid, word, cout, ovf);
      else n_pass++;
      $display("txn overflow: w=%h ovf=%b", word, ovf);
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0 || ovf !== 1'b1)
         $display("FAIL ovf_sticky: got v=%b o=%b want v=0 o=1", out_valid, ovf);
      else n_pass++;
      step();
      n_checks++;
      if (ovf !== 1'b1)
         $display("FAIL ovf_sticky2: got %b want 1", ovf);
      else n_pass++;
   endtask

   task automatic test_reset_midword();
      out_ready = 1'b1;
      send_digit(4'h7, 1'b0);
      send_digit(4'h8, 1'b0);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      s        = 4'hF;
      c        = 1'b1;
      step();
      n_checks++;
      if ({out_valid, word, cout, ovf} !== 15'd0)
         $display("FAIL midreset_outputs: got v=%b w=%h c=%b o=%b want all 0", out_valid, word, cout, ovf);
      else n_pass++;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      c        = 1'b0;
      step();
      send_digit(4'h4, 1'b0);
      send_digit(4'h5, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0)
         $display("FAIL midreset_early: got %b want 0", out_valid);
      else n_pass++;
      send_digit(4'h6, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || word !== 12'h654 || cout !== 1'b0 || ovf !== 1'b0)
         $display("FAIL midreset_word: got v=%b w=%h c=%b o=%b want v=1 w=654 c=0 o=0", out_valid, word, cout, ovf);
      else n_pass++;
      $display("txn midreset: w=%h", word);
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_back_to_back();
      test_overflow();
      test_reset_midword();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
